wrr_credit_arbiter: RTL and testbench
=====================================

Name: wrr_credit_arbiter

Overview:
- Parametrised weighted round-robin arbiter with per-requestor programmable weights, credit counters and automatic credit replenish.
- Registered one-hot grant with a valid/ready handshake toward the shared resource.
- Fair replacement for fixed-weight arbitration in bus and shared-port muxing paths.
- Never stalls permanently: when every pending requestor is out of credit, all credits reload.

Parameters:
- NUM_REQ, 8, number of requestors (2..32).
- WEIGHT_W, 4, width of each weight and credit counter.
- DEFAULT_WEIGHT, 3, weight loaded into every requestor at reset (must be < 2**WEIGHT_W).
- ID_W, $clog2(NUM_REQ), width of gnt_id (derived, not overridden).

Ports:
- clk, input, 1, clock.
- rst_b, input, 1, reset: asynchronous, active-low.
- req, input, NUM_REQ, request per requestor, level-sensitive.
- weight_cfg, input, NUM_REQ*WEIGHT_W, new weights; requestor i occupies bits [i*WEIGHT_W +: WEIGHT_W].
- cfg_load, input, 1, single-cycle pulse that captures weight_cfg.
- gnt_valid, output, 1, a grant is being presented.
- gnt_ready, input, 1, downstream accepts the grant.
- gnt, output, NUM_REQ, one-hot grant; zero when gnt_valid=0.
- gnt_id, output, ID_W, binary index of the granted requestor.

Behaviour:
- Reset values:
  - weight[i] = credit[i] = DEFAULT_WEIGHT.
  - ptr = 0.
  - gnt_valid = 0, gnt = 0, gnt_id = 0.
- eligible[i] = req[i] & (credit_nxt[i] != 0).
  - credit_nxt is the credit value after this cycle's decrement or reload.
  - weight 0 permanently disables requestor i.
- Arbitration slot opens when gnt_valid=0, or when gnt_valid & gnt_ready.
- Pick rule: first eligible index searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
- Latency: req asserted in cycle N with a free slot gives gnt_valid=1 in cycle N+1, driven from registers.
- Back-to-back: in an accept cycle, the next grant is registered on the same edge, so there are no bubbles.
- Hold rule: while gnt_valid & !gnt_ready, gnt and gnt_id stay stable even if req drops.
  - Grants are sticky; no re-arbitration while a grant is held.
- On accept of requestor k:
  - credit[k] decrements by 1.
  - ptr = (k+1) mod NUM_REQ.
- Replenish: occurs when the slot is open, some req[i] has weight[i] != 0, and no index is eligible.
  - All credit[i] reload to weight[i].
  - No grant is issued on that edge; the grant appears on the following cycle.
  - ptr is unchanged.
- No request at all, or only weight-0 requests: gnt_valid=0, credits untouched, no replenish.
- cfg_load:
  - weight[i] = weight_cfg slice and credit[i] = new weight on the next edge.
  - An outstanding grant is held and completes normally.
  - When cfg_load coincides with an accept, the reload wins and no decrement is applied; ptr still advances.
  - No arbitration occurs in a cfg_load cycle; the slot re-opens next cycle.
- Credit arithmetic is unsigned WEIGHT_W bits. A decrement is only ever applied to a nonzero credit, so it never underflows.
- Reset asserted mid-handshake: outputs clear asynchronously and the pending grant is dropped.

Optional Feature:
- Macro: WRR_REPLENISH_STAT_EN.
- With the macro:
  - Adds output replenish_pulse (1 bit), high for one cycle on every replenish edge.
  - Adds output replenish_cnt (16 bits), which counts replenish events, saturates at 0xFFFF, and resets to 0.
- Without the macro: neither port nor the counter logic exists.

Decomposition:
- Package wrr_pkg holds:
  - typedef weight_t (logic [WEIGHT_W-1:0]).
  - localparam STAT_CNT_W = 16.
  - function onehot_to_idx.
- Sub-module wrr_rr_pick: combinational rotating priority picker.
  - Inputs: eligible vector, ptr.
  - Outputs: one-hot pick and any_valid.
  - Instantiated once.

Test Plan:
- Reset, then NUM_REQ=3, weights 4/4/4, req=101, gnt_ready=1 constantly:
  - grants 001,100,001,100,001,100,001,100;
  - then 1 idle cycle for replenish;
  - then the pattern repeats.
- Weights 1/3/0, req=111, ready=1:
  - per replenish window: 001,010,010,010, then replenish;
  - requestor 2 is never granted.
- Backpressure: req=010, gnt_ready low for 5 cycles:
  - gnt=010 and gnt_id=1 held stable;
  - req dropped in cycle 2 does not change the grant;
  - credit[1] decrements only on the accept cycle.
- cfg_load with weight_cfg=2/2/2 in the same cycle as an accept of requestor 0:
  - next-cycle credits are 2/2/2 with no decrement;
  - ptr = 1.
- req=000 for 10 cycles from reset: gnt_valid=0 and credits stay 3/3/3, no replenish.
- WRR_REPLENISH_STAT_EN defined, weights 1/1, req=11, ready=1 for 12 cycles:
  - replenish_pulse fires every 3rd cycle;
  - replenish_cnt = 4.

Source files
------------

// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin credit arbiter.
//
// Contents:
//   weight_t       - weight/credit word at the default width (4 bits)
//   STAT_CNT_W     - width of the optional replenish event counter
//   onehot_to_idx  - binary index of the set bit in a one-hot word (up to 32)
package wrr_pkg;

  localparam int WEIGHT_W_DEFAULT = 4;
  localparam int STAT_CNT_W       = 16;

  typedef logic [WEIGHT_W_DEFAULT-1:0] weight_t;

  // Callers zero-extend narrower vectors to 32 bits and truncate the result
  // to their own index width. A zero input returns index 0.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] onehot);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_rr_pick.sv
// Combinational rotating-priority picker.
//
// Ports:
//   eligible  [NUM_REQ] - candidates for this arbitration slot
//   ptr       [ID_W]    - highest-priority index (search starts here, wraps)
//   pick      [NUM_REQ] - one-hot winner, zero when nothing is eligible
//   any_valid           - at least one candidate was eligible
module wrr_rr_pick #(
  parameter  int NUM_REQ = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any_valid
);

  always_comb begin
    int idx;
    pick      = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr is always below NUM_REQ, so one subtraction wraps correctly
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && eligible[idx]) begin
        pick[idx] = 1'b1;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_credit_arbiter.sv
// Weighted round-robin arbiter with per-requestor credit counters.
//
// Each requestor holds a programmable weight and a credit counter. An accepted
// grant costs one credit; a requestor with no credit left is skipped. When
// requests are pending but nobody has credit, every counter reloads from its
// weight (one idle cycle), so the arbiter never stalls. Weight 0 disables a
// requestor permanently.
//
// Ports:
//   clk, rst_b            - clock, asynchronous active-low reset
//   req        [NUM_REQ]  - level-sensitive requests
//   weight_cfg [NUM_REQ*WEIGHT_W] - new weights, requestor i at [i*WEIGHT_W +: WEIGHT_W]
//   cfg_load              - one-cycle pulse capturing weight_cfg (also reloads credits)
//   gnt_valid / gnt_ready - grant handshake toward the shared resource
//   gnt        [NUM_REQ]  - registered one-hot grant, zero when gnt_valid=0
//   gnt_id     [ID_W]     - binary index of the granted requestor
//
// Optional build macro WRR_REPLENISH_STAT_EN adds:
//   replenish_pulse       - one-cycle pulse after every replenish edge
//   replenish_cnt  [16]   - saturating count of replenish events
module wrr_credit_arbiter
  import wrr_pkg::*;
#(
  parameter  int NUM_REQ        = 8,
  parameter  int WEIGHT_W       = 4,
  parameter  int DEFAULT_WEIGHT = 3,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*WEIGHT_W-1:0] weight_cfg,
  input  logic                        cfg_load,
  output logic                        gnt_valid,
  input  logic                        gnt_ready,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [ID_W-1:0]             gnt_id
`ifdef WRR_REPLENISH_STAT_EN
  ,
  output logic                        replenish_pulse,
  output logic [STAT_CNT_W-1:0]       replenish_cnt
`endif
);

  logic [WEIGHT_W-1:0] weight_q   [NUM_REQ];
  logic [WEIGHT_W-1:0] weight_d   [NUM_REQ];
  logic [WEIGHT_W-1:0] credit_q   [NUM_REQ];
  logic [WEIGHT_W-1:0] credit_d   [NUM_REQ];
  logic [WEIGHT_W-1:0] credit_dec [NUM_REQ];

  logic [ID_W-1:0]     ptr_q, ptr_d, ptr_adv;
  logic                gnt_valid_q, gnt_valid_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;

  logic                accept;
  logic                slot_open;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  req_live;
  logic [NUM_REQ-1:0]  pick;
  logic                any_valid;
  logic [31:0]         pick_ext;

  // Credit after this cycle's accept, and the pointer after this cycle's
  // advance. Arbitrating on these lets an accept cycle register the next grant
  // on the same edge without re-picking the requestor just served.
  always_comb begin
    accept    = gnt_valid_q & gnt_ready;
    slot_open = !gnt_valid_q | accept;

    ptr_adv = ptr_q;
    if (accept) begin
      ptr_adv = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      credit_dec[i] = credit_q[i];
      // Guarded so a credit zeroed by a reconfiguration under a held grant
      // cannot wrap on the accept.
      if (accept && gnt_q[i] && (credit_q[i] != '0)) begin
        credit_dec[i] = credit_q[i] - WEIGHT_W'(1);
      end
      eligible[i] = req[i] & (credit_dec[i] != '0);
      req_live[i] = req[i] & (weight_q[i] != '0);
    end
  end

  wrr_rr_pick #(
    .NUM_REQ   (NUM_REQ)
  ) u_pick (
    .eligible  (eligible),
    .ptr       (ptr_adv),
    .pick      (pick),
    .any_valid (any_valid)
  );

  always_comb begin
    pick_ext                = '0;
    pick_ext[NUM_REQ-1:0]   = pick;
  end

  always_comb begin
    weight_d    = weight_q;
    credit_d    = credit_q;
    ptr_d       = ptr_q;
    gnt_valid_d = gnt_valid_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;

    if (cfg_load) begin
      // Reload beats any decrement; a held grant stays held, an accepted one
      // completes and the slot reopens on the next cycle.
      for (int i = 0; i < NUM_REQ; i++) begin
        weight_d[i] = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
        credit_d[i] = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
      end
      if (accept) begin
        ptr_d       = ptr_adv;
        gnt_valid_d = 1'b0;
        gnt_d       = '0;
      end
    end else if (slot_open) begin
      ptr_d = ptr_adv;
      if (any_valid) begin
        gnt_valid_d = 1'b1;
        gnt_d       = pick;
        gnt_id_d    = ID_W'(onehot_to_idx(pick_ext));
        credit_d    = credit_dec;
      end else begin
        gnt_valid_d = 1'b0;
        gnt_d       = '0;
        if (|req_live) begin
          credit_d = weight_q;
        end else begin
          credit_d = credit_dec;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
        credit_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
      end
      ptr_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
    end else begin
      weight_q    <= weight_d;
      credit_q    <= credit_d;
      ptr_q       <= ptr_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;

`ifdef WRR_REPLENISH_STAT_EN
  logic                  replenish_evt;
  logic                  replenish_pulse_q, replenish_pulse_d;
  logic [STAT_CNT_W-1:0] replenish_cnt_q, replenish_cnt_d;

  // Same condition that selects the credit reload above.
  assign replenish_evt = !cfg_load & slot_open & !any_valid & (|req_live);

  always_comb begin
    replenish_pulse_d = replenish_evt;
    replenish_cnt_d   = replenish_cnt_q;
    if (replenish_evt && (replenish_cnt_q != '1)) begin
      replenish_cnt_d = replenish_cnt_q + STAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      replenish_pulse_q <= 1'b0;
      replenish_cnt_q   <= '0;
    end else begin
      replenish_pulse_q <= replenish_pulse_d;
      replenish_cnt_q   <= replenish_cnt_d;
    end
  end

  assign replenish_pulse = replenish_pulse_q;
  assign replenish_cnt   = replenish_cnt_q;
`endif

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
module tb_wrr_credit_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int WEIGHT_W = 4;
  localparam int ID_W     = 2;

  logic                        clk;
  logic                        rst_b;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*WEIGHT_W-1:0] weight_cfg;
  logic                        cfg_load;
  logic                        gnt_valid;
  logic                        gnt_ready;
  logic [NUM_REQ-1:0]          gnt;
  logic [ID_W-1:0]             gnt_id;
`ifdef WRR_REPLENISH_STAT_EN
  logic                        replenish_pulse;
  logic [15:0]                 replenish_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  wrr_credit_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .WEIGHT_W       (WEIGHT_W),
    .DEFAULT_WEIGHT (3)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req        (req),
    .weight_cfg (weight_cfg),
    .cfg_load   (cfg_load),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
`ifdef WRR_REPLENISH_STAT_EN
    ,
    .replenish_pulse (replenish_pulse),
    .replenish_cnt   (replenish_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b      = 1'b0;
    req        = '0;
    gnt_ready  = 1'b0;
    cfg_load   = 1'b0;
    weight_cfg = '0;
    step();
    step();
    rst_b = 1'b1;
  endtask

  task automatic load_weights(input logic [3:0] w2, input logic [3:0] w1, input logic [3:0] w0);
    weight_cfg = {w2, w1, w0};
    cfg_load   = 1'b1;
    step();
    cfg_load   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (gnt_valid !== 1'b0 || gnt !== 3'b000 || gnt_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b gnt=%b id=%0d, required 0/000/0", gnt_valid, gnt, gnt_id);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      n_tests++;
      if (dut.credit_q[i] !== 4'd3 || dut.weight_q[i] !== 4'd3) begin
        n_fail++;
        $display("FAIL reset_credit[%0d]: credit=%0d weight=%0d, required 3/3", i, dut.credit_q[i], dut.weight_q[i]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: got %0d, required 0", dut.ptr_q);
    end
    // Reset asserted while a grant is being held must clear it without a clock edge.
    req = 3'b001;
    step();
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_pregrant: valid=%b gnt=%b, required 1/001", gnt_valid, gnt);
    end
    rst_b = 1'b0;
    #2;
    n_tests++;
    if (gnt_valid !== 1'b0 || gnt !== 3'b000 || gnt_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b gnt=%b id=%0d, required 0/000/0", gnt_valid, gnt, gnt_id);
    end
    req = '0;
    step();
    rst_b = 1'b1;
  endtask

  task automatic test_idle();
    do_reset();
    req = 3'b000;
    gnt_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (gnt_valid !== 1'b0 || gnt !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: valid=%b gnt=%b, required 0/000", c, gnt_valid, gnt);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      n_tests++;
      if (dut.credit_q[i] !== 4'd3) begin
        n_fail++;
        $display("FAIL idle_credit[%0d]: got %0d, required 3", i, dut.credit_q[i]);
      end
    end
  endtask

  task automatic test_equal_weights();
    logic [2:0] exp_gnt [18];
    exp_gnt = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b000,
                3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b000};
    do_reset();
    load_weights(4'd4, 4'd4, 4'd4);
    req = 3'b101;
    gnt_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      step();
      n_tests++;
      if (gnt !== exp_gnt[c] || gnt_valid !== (exp_gnt[c] != 3'b000)) begin
        n_fail++;
        $display("FAIL equal_w_cycle%0d: gnt=%b valid=%b, required %b", c, gnt, gnt_valid, exp_gnt[c]);
      end
    end
    req = '0;
    gnt_ready = 1'b0;
  endtask

  task automatic test_weights_130();
    logic [2:0] exp_gnt [10];
    logic [1:0] exp_id  [10];
    exp_gnt = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001, 3'b010, 3'b010, 3'b010, 3'b000};
    exp_id  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    do_reset();
    load_weights(4'd0, 4'd3, 4'd1);
    req = 3'b111;
    gnt_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (gnt !== exp_gnt[c] || (exp_gnt[c] != 3'b000 && gnt_id !== exp_id[c])) begin
        n_fail++;
        $display("FAIL w130_cycle%0d: gnt=%b id=%0d, required %b id %0d", c, gnt, gnt_id, exp_gnt[c], exp_id[c]);
      end
    end
    req = '0;
    gnt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 3'b010;
    gnt_ready = 1'b0;
    n_tests++;
    if (gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_before_grant: valid=%b, required 0", gnt_valid);
    end
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req = 3'b000;
      n_tests++;
      if (gnt_valid !== 1'b1 || gnt !== 3'b010 || gnt_id !== 2'd1 || dut.credit_q[1] !== 4'd3) begin
        n_fail++;
        $display("FAIL bp_hold_cycle%0d: valid=%b gnt=%b id=%0d credit1=%0d, required 1/010/1/3",
                 c, gnt_valid, gnt, gnt_id, dut.credit_q[1]);
      end
    end
    gnt_ready = 1'b1;
    step();
    n_tests++;
    if (gnt_valid !== 1'b0 || dut.credit_q[1] !== 4'd2 || dut.ptr_q !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_accept: valid=%b credit1=%0d ptr=%0d, required 0/2/2",
               gnt_valid, dut.credit_q[1], dut.ptr_q);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_cfg_accept();
    do_reset();
    req = 3'b001;
    gnt_ready = 1'b0;
    step();
    n_tests++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL cfg_pregrant: gnt=%b, required 001", gnt);
    end
    gnt_ready  = 1'b1;
    weight_cfg = {4'd2, 4'd2, 4'd2};
    cfg_load   = 1'b1;
    step();
    cfg_load   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_tests++;
      if (dut.credit_q[i] !== 4'd2 || dut.weight_q[i] !== 4'd2) begin
        n_fail++;
        $display("FAIL cfg_credit[%0d]: credit=%0d weight=%0d, required 2/2", i, dut.credit_q[i], dut.weight_q[i]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 2'd1 || gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_ptr_slot: ptr=%0d valid=%b, required 1/0", dut.ptr_q, gnt_valid);
    end
    step();
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt !== 3'b001 || gnt_id !== 2'd0) begin
      n_fail++;
      $display("FAIL cfg_regrant: valid=%b gnt=%b id=%0d, required 1/001/0", gnt_valid, gnt, gnt_id);
    end
    req = '0;
    gnt_ready = 1'b0;
  endtask

`ifdef WRR_REPLENISH_STAT_EN
  task automatic test_replenish_stat();
    int pulses;
    pulses = 0;
    do_reset();
    load_weights(4'd0, 4'd1, 4'd1);
    req = 3'b011;
    gnt_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (replenish_pulse === 1'b1) pulses++;
      n_tests++;
      if (replenish_pulse !== ((c % 3) == 0)) begin
        n_fail++;
        $display("FAIL stat_pulse_cycle%0d: got %b, required %b", c, replenish_pulse, ((c % 3) == 0));
      end
    end
    n_tests++;
    if (pulses != 4 || replenish_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL stat_count: pulses=%0d cnt=%0d, required 4/4", pulses, replenish_cnt);
    end
    req = '0;
    gnt_ready = 1'b0;
  endtask
`endif

  initial begin
    rst_b      = 1'b0;
    req        = '0;
    gnt_ready  = 1'b0;
    cfg_load   = 1'b0;
    weight_cfg = '0;
    test_reset();
    test_idle();
    test_equal_weights();
    test_weights_130();
    test_backpressure();
    test_cfg_accept();
`ifdef WRR_REPLENISH_STAT_EN
    test_replenish_stat();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
